// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared types and AXI constants for the instruction-side read bridge.
package inst_axi_rd_bridge_pkg;

  typedef logic [31:0] word_t;

  // AR channel state: idle (may accept a fetch) or presenting an address
  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RRESP_OKAY = 2'b00;

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// Bundle of the if_stage SRAM-like port and the AXI AR/R channels.
// master: the bridge itself (AXI master, SRAM-port responder).
// slave:  its environment (if_stage plus the AXI read slave).
interface inst_axi_rd_bridge_if;
  import inst_axi_rd_bridge_pkg::*;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  word_t       inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  word_t       inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  word_t       inst_sram_rdata;

  logic [3:0]  arid;
  word_t       araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  word_t       rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        rd_err;
  logic        rd_err_sticky;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready, rd_err, rd_err_sticky
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready, rd_err, rd_err_sticky
  );

endinterface

// File: rtl/inst_axi_rd_bridge_outstanding_cnt.sv
// Saturating up/down counter of reads accepted but not yet returned.
module inst_axi_rd_bridge_outstanding_cnt #(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt,
  output logic       full,
  output logic       empty
);

  assign full  = (cnt == 2'(MAX));
  assign empty = (cnt == 2'd0);

  // Count up on accept, down on return; simultaneous events cancel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      case ({inc, dec})
        2'b10:   if (!full)  cnt <= cnt + 2'd1;
        2'b01:   if (!empty) cnt <= cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: SRAM-like fetch requests to single-beat AXI4 reads.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_axi_rd_bridge_if.master  bus
);

  ar_state_t  state, state_nxt;
  logic       addr_ok;
  logic       arvalid;
  logic       r_hs;
  logic [1:0] cnt;
  logic       cnt_full;
  logic       cnt_empty;
  word_t      araddr_q;
  logic [2:0] arsize_q;
  logic       vld_p1;
  word_t      rdata_p1;
  logic       err_p1;
  logic       err_sticky;
  logic       unused_inputs;

  assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata};

  assign r_hs = bus.rvalid && bus.rready;

  inst_axi_rd_bridge_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (addr_ok),
    .dec   (r_hs),
    .cnt   (cnt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

  // AR state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= AR_IDLE;
    else       state <= state_nxt;
  end

  // AR next-state: leave idle on accept, return once the address is taken
  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (addr_ok)     state_nxt = AR_SEND;
      AR_SEND: if (bus.arready) state_nxt = AR_IDLE;
      default:                  state_nxt = AR_IDLE;
    endcase
  end

  // AR outputs: a slot freed by a returning beat may be reused this cycle
  always_comb begin
    addr_ok = 1'b0;
    arvalid = 1'b0;
    case (state)
      AR_IDLE: addr_ok = bus.inst_sram_req && (!cnt_full || r_hs);
      AR_SEND: arvalid = 1'b1;
      default: ;
    endcase
  end

  // Capture the fetch address/size so AR stays stable while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_q <= '0;
      arsize_q <= 3'd0;
    end else if (addr_ok) begin
      araddr_q <= bus.inst_sram_addr;
      arsize_q <= {1'b0, bus.inst_sram_size};
    end
  end

  // p0 -> p1: registered return of each R beat to if_stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      rdata_p1   <= '0;
      err_p1     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      vld_p1 <= r_hs;
      err_p1 <= r_hs && (bus.rresp != AXI_RRESP_OKAY);
      if (r_hs) rdata_p1 <= bus.rdata;
      if (r_hs && (bus.rresp != AXI_RRESP_OKAY)) err_sticky <= 1'b1;
    end
  end

  // Protocol monitors for if_stage and the AXI slave (warnings only)
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.inst_sram_req && bus.inst_sram_wr))
        else $warning("inst bridge: write request not supported");
      if (bus.rvalid)
        assert (cnt != 2'd0) else $warning("inst bridge: R beat with nothing outstanding");
      if (r_hs) begin
        assert (bus.rid == AXI_ID) else $warning("inst bridge: unexpected rid %0h", bus.rid);
        assert (bus.rlast) else $warning("inst bridge: rlast low on single-beat read");
      end
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = vld_p1;
  assign bus.inst_sram_rdata   = rdata_p1;
  assign bus.arid              = AXI_ID;
  assign bus.araddr            = araddr_q;
  assign bus.arlen             = 8'd0;
  assign bus.arsize            = arsize_q;
  assign bus.arburst           = AXI_BURST_INCR;
  assign bus.arlock            = 2'd0;
  assign bus.arcache           = 4'd0;
  assign bus.arprot            = 3'd0;
  assign bus.arvalid           = arvalid;
  assign bus.rready            = !cnt_empty;
  assign bus.rd_err            = err_p1;
  assign bus.rd_err_sticky     = err_sticky;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge; the AXI slave is played step by step.
module tb_inst_axi_rd_bridge;
  import inst_axi_rd_bridge_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  inst_axi_rd_bridge_if bus ();

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
      end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'd0;
    bus.inst_sram_addr  = 32'h0;
    bus.inst_sram_wstrb = 4'h0;
    bus.inst_sram_wdata = 32'h0;
    bus.arready = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b1;
    bus.rvalid  = 1'b0;

    // reset state
    cyc(); mid();
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_araddr",  bus.araddr, 32'h0);
    chk("rst_arsize",  32'(bus.arsize), 32'd0);
    chk("rst_rready",  32'(bus.rready), 32'd0);
    chk("rst_data_ok", 32'(bus.inst_sram_data_ok), 32'd0);
    chk("rst_rdata",   bus.inst_sram_rdata, 32'h0);
    chk("rst_rd_err",  32'(bus.rd_err), 32'd0);
    chk("rst_sticky",  32'(bus.rd_err_sticky), 32'd0);
    cyc(); reset = 1'b0;

    // single fetch, 3-cycle latency
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000000;
    bus.inst_sram_size = 2'd2; bus.arready = 1'b1;
    mid(); chk("t1_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0;
    mid(); chk("t1_arvalid", 32'(bus.arvalid), 32'd1);
    chk("t1_araddr",  bus.araddr, 32'h1c000000);
    chk("t1_arsize",  32'(bus.arsize), 32'(AXI_SIZE_4B));
    chk("t1_arid",    32'(bus.arid), 32'd0);
    chk("t1_arlen",   32'(bus.arlen), 32'd0);
    chk("t1_arburst", 32'(bus.arburst), 32'd1);
    cyc(); bus.rvalid = 1'b1; bus.rdata = 32'h02800000; bus.rresp = 2'b00;
    mid(); chk("t1_rready", 32'(bus.rready), 32'd1);
    chk("t1_ok_early", 32'(bus.inst_sram_data_ok), 32'd0);
    chk("t1_ar_done",  32'(bus.arvalid), 32'd0);
    cyc(); bus.rvalid = 1'b0;
    mid(); chk("t1_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t1_rdata",  bus.inst_sram_rdata, 32'h02800000);
    chk("t1_rd_err", 32'(bus.rd_err), 32'd0);
    cyc();
    mid(); chk("t1_ok_pulse", 32'(bus.inst_sram_data_ok), 32'd0);

    // AR stall for 5 cycles, second request held off
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000040; bus.arready = 1'b0;
    mid(); chk("t2_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.inst_sram_addr = 32'h1c000044;
      mid(); chk("t2_stall_arvalid", 32'(bus.arvalid), 32'd1);
      chk("t2_stall_araddr", bus.araddr, 32'h1c000040);
      chk("t2_stall_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
    end
    cyc(); bus.arready = 1'b1;
    mid(); chk("t2_hs_arvalid", 32'(bus.arvalid), 32'd1);
    chk("t2_hs_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc(); bus.inst_sram_req = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h11111111;
    mid(); chk("t2_ar_done", 32'(bus.arvalid), 32'd0);
    chk("t2_rready", 32'(bus.rready), 32'd1);
    cyc(); bus.rvalid = 1'b0;
    mid(); chk("t2_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t2_rdata", bus.inst_sram_rdata, 32'h11111111);

    // outstanding limit of 2, in-order return
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000000;
    mid(); chk("t3_ok0", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_addr = 32'h1c000004;
    mid(); chk("t3_send0", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc();
    mid(); chk("t3_ok1", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_addr = 32'h1c000008;
    mid(); chk("t3_send1", 32'(bus.inst_sram_addr_ok), 32'd0);
    chk("t3_araddr1", bus.araddr, 32'h1c000004);
    cyc();
    mid(); chk("t3_full_a", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc();
    mid(); chk("t3_full_b", 32'(bus.inst_sram_addr_ok), 32'd0);
    cyc(); bus.rvalid = 1'b1; bus.rdata = 32'haaaa0000;
    mid(); chk("t3_ok2_on_r", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; bus.rdata = 32'haaaa0004;
    mid(); chk("t3_d0_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t3_d0", bus.inst_sram_rdata, 32'haaaa0000);
    chk("t3_araddr2", bus.araddr, 32'h1c000008);
    cyc(); bus.rdata = 32'haaaa0008;
    mid(); chk("t3_d4", bus.inst_sram_rdata, 32'haaaa0004);
    cyc(); bus.rvalid = 1'b0;
    mid(); chk("t3_d8", bus.inst_sram_rdata, 32'haaaa0008);
    chk("t3_d8_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t3_drained", 32'(bus.rready), 32'd0);

    // error response on the second of two reads
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000010;
    mid(); chk("t4_ok0", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_addr = 32'h1c000014;
    mid();
    cyc();
    mid(); chk("t4_ok1", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0;
    mid(); chk("t4_araddr1", bus.araddr, 32'h1c000014);
    cyc(); bus.rvalid = 1'b1; bus.rdata = 32'hb0b0b0b0; bus.rresp = 2'b00;
    mid();
    cyc(); bus.rdata = 32'hb1b1b1b1; bus.rresp = 2'b10;
    mid(); chk("t4_first_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t4_first_err", 32'(bus.rd_err), 32'd0);
    chk("t4_first_sticky", 32'(bus.rd_err_sticky), 32'd0);
    cyc(); bus.rvalid = 1'b0; bus.rresp = 2'b00;
    mid(); chk("t4_second_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t4_second_data", bus.inst_sram_rdata, 32'hb1b1b1b1);
    chk("t4_second_err", 32'(bus.rd_err), 32'd1);
    cyc();
    mid(); chk("t4_err_pulse", 32'(bus.rd_err), 32'd0);
    chk("t4_sticky", 32'(bus.rd_err_sticky), 32'd1);

    // asynchronous reset while in AR_SEND with one read outstanding
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000020; bus.arready = 1'b0;
    mid(); chk("t5_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0;
    mid(); chk("t5_send", 32'(bus.arvalid), 32'd1);
    chk("t5_cnt1", 32'(bus.rready), 32'd1);
    #1; reset = 1'b1;
    #1; chk("t5_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t5_rst_cnt", 32'(bus.rready), 32'd0);
    chk("t5_rst_araddr", bus.araddr, 32'h0);
    chk("t5_rst_data_ok", 32'(bus.inst_sram_data_ok), 32'd0);
    chk("t5_rst_sticky", 32'(bus.rd_err_sticky), 32'd0);
    cyc(); reset = 1'b0; bus.arready = 1'b1;

    // fetch after reset, then accept and return in the same cycle
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000030;
    mid(); chk("t6_ok0", 32'(bus.inst_sram_addr_ok), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0;
    mid(); chk("t6_araddr0", bus.araddr, 32'h1c000030);
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000034;
    bus.rvalid = 1'b1; bus.rdata = 32'hcccc0030;
    mid(); chk("t6_ok_with_r", 32'(bus.inst_sram_addr_ok), 32'd1);
    chk("t6_rready", 32'(bus.rready), 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; bus.rvalid = 1'b0;
    mid(); chk("t6_d0_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    chk("t6_d0", bus.inst_sram_rdata, 32'hcccc0030);
    chk("t6_cnt_kept", 32'(bus.rready), 32'd1);
    chk("t6_araddr1", bus.araddr, 32'h1c000034);
    cyc(); bus.rvalid = 1'b1; bus.rdata = 32'hcccc0034;
    mid(); chk("t6_gap", 32'(bus.inst_sram_data_ok), 32'd0);
    cyc(); bus.rvalid = 1'b0;
    mid(); chk("t6_d1", bus.inst_sram_rdata, 32'hcccc0034);
    chk("t6_d1_ok", 32'(bus.inst_sram_data_ok), 32'd1);
    cyc();
    mid(); chk("t6_drained", 32'(bus.rready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
